alu_operand_sequencer: RTL

Upstream operand loader for the 8-bit ALU in the Tiny Tapeout top. The 8-pin input bus cannot carry A, B and the operation select at once, so this block collects them as three bytes, one per strobe on a handshake pin. It then holds them stable on the ALU inputs, registers the ALU's combinational result, and presents it with a one-cycle valid pulse for the output pins.

---
 rtl/alu_operand_sequencer_pkg.sv | 39 +++
 rtl/alu_operand_sequencer_sync_edge_det.sv | 43 ++++
 rtl/alu_operand_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer (package alu_seq_pkg).
// Holds the FSM state encoding, the phase codes reported on the phase
// output, and the bit positions of the fields in the OP byte.
package alu_seq_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned SEL_LSB   = 0;
  localparam int unsigned CHAIN_BIT = 7;
  localparam int unsigned STATE_W   = 2;
  localparam int unsigned PHASE_W   = 2;

  // FSM state encoding
  localparam logic [STATE_W-1:0] ST_LOAD_A  = 2'd0;
  localparam logic [STATE_W-1:0] ST_LOAD_B  = 2'd1;
  localparam logic [STATE_W-1:0] ST_LOAD_OP = 2'd2;
  localparam logic [STATE_W-1:0] ST_EXEC    = 2'd3;

  // Phase codes: which byte is expected next
  localparam logic [PHASE_W-1:0] PH_A    = 2'd0;
  localparam logic [PHASE_W-1:0] PH_B    = 2'd1;
  localparam logic [PHASE_W-1:0] PH_OP   = 2'd2;
  localparam logic [PHASE_W-1:0] PH_EXEC = 2'd3;

  // Map an FSM state onto the externally visible phase code
  function automatic logic [PHASE_W-1:0] phase_of(input logic [STATE_W-1:0] st);
    logic [PHASE_W-1:0] ph;
    ph = PH_A;
    case (st)
      ST_LOAD_A:  ph = PH_A;
      ST_LOAD_B:  ph = PH_B;
      ST_LOAD_OP: ph = PH_OP;
      ST_EXEC:    ph = PH_EXEC;
      default:    ph = PH_A;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/alu_operand_sequencer_sync_edge_det.sv
// sync_edge_det: brings an asynchronous pin level into the clk domain through
// a 2-FF synchronizer, keeps one history FF and flags its rising edge.
// Ports:
//   clk      in  1  system clock
//   rst      in  1  synchronous active-high reset
//   async_i  in  1  asynchronous level from a pin
//   pulse_c  out 1  one-cycle rising-edge pulse (combinational from flops)
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic pulse_c
);

  logic       s1_q;
  logic       s2_q;
  logic       s3_q;
  logic [1:0] vld_q;
  logic       armed_q;

  // Synchronizer, history FF and arming.
  // After reset the sync FFs hold zeros that were never sampled from the pin,
  // so a level already high would look like a fresh edge. vld_q marks when s2
  // carries a real sample; detection is armed only once s2 has really been low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= async_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_q | (vld_q[1] & ~s2_q);
    end
  end

  assign pulse_c = s2_q & ~s3_q & armed_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: collects operand A, operand B and the OP byte from an
// 8-bit pin bus (one byte per load strobe rising edge), holds them on the ALU
// inputs, registers the ALU result and flags it with a one-cycle valid pulse.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ena               tile enable; low ignores strobes and holds state
//   data_in[7:0]      byte bus
//   load_stb          asynchronous load strobe level
//   alu_a/alu_b[7:0]  registered operands to the ALU
//   alu_sel[1:0]      registered operation select
//   alu_result[7:0]   combinational ALU result
//   result[7:0]       registered result
//   result_valid      one-cycle pulse when result updates
//   busy              high while executing
//   phase[1:0]        next expected byte: 0=A 1=B 2=OP 3=executing
// Build option: define OPSEQ_CHAIN_EN to enable accumulator chaining via OP bit 7.
module alu_operand_sequencer
  import alu_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                load_stb,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [SEL_W-1:0]    alu_sel,
  input  logic [DATA_W-1:0]   alu_result,
  output logic [DATA_W-1:0]   result,
  output logic                result_valid,
  output logic                busy,
  output logic [PHASE_W-1:0]  phase
);

  logic                stb_p;
  logic                stb_ok;

  logic [STATE_W-1:0]  state_q,   state_d;
  logic [DATA_W-1:0]   alu_a_q,   alu_a_d;
  logic [DATA_W-1:0]   alu_b_q,   alu_b_d;
  logic [SEL_W-1:0]    alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0]   result_q,  result_d;
  logic                valid_q,   valid_d;
  logic                busy_q,    busy_d;
  logic [PHASE_W-1:0]  phase_q,   phase_d;
`ifdef OPSEQ_CHAIN_EN
  logic                chain_q,   chain_d;
`endif

  sync_edge_det u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (load_stb),
    .pulse_c (stb_p)
  );

  // Strobes count only when enabled and while a byte is expected
  assign stb_ok = stb_p & ena & (state_q != ST_EXEC);

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    result_d  = result_q;
    valid_d   = 1'b0;
`ifdef OPSEQ_CHAIN_EN
    chain_d   = chain_q;
`endif
    case (state_q)
      ST_LOAD_A: begin
        if (stb_ok) begin
          alu_a_d = data_in;
          state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        if (stb_ok) begin
          alu_b_d = data_in;
          state_d = ST_LOAD_OP;
        end
      end
      ST_LOAD_OP: begin
        if (stb_ok) begin
          alu_sel_d = data_in[SEL_LSB +: SEL_W];
`ifdef OPSEQ_CHAIN_EN
          chain_d   = data_in[CHAIN_BIT];
`endif
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Not gated by ena: committed operands always produce a result
        result_d = alu_result;
        valid_d  = 1'b1;
        state_d  = ST_LOAD_A;
`ifdef OPSEQ_CHAIN_EN
        if (chain_q) begin
          alu_a_d = alu_result;
          state_d = ST_LOAD_B;
        end
`endif
      end
      default: state_d = ST_LOAD_A;
    endcase
    // Status outputs registered from the next state so they track state_q
    busy_d  = (state_d == ST_EXEC);
    phase_d = phase_of(state_d);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_LOAD_A;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      phase_q   <= PH_A;
`ifdef OPSEQ_CHAIN_EN
      chain_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      phase_q   <= phase_d;
`ifdef OPSEQ_CHAIN_EN
      chain_q   <= chain_d;
`endif
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_sel      = alu_sel_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;
  assign phase        = phase_q;

endmodule
